// File: rtl/interrupt_controller_if.sv
// Bus between the interrupt controller and the multicycle control FSM.
//
// Handshake: IntReq acts as "valid" and IntAck as "ready". A request is
// transferred on the rising CLK edge where IntReq=1 and IntAck=1; IntReq
// stays high and IntCause/VectorAddr stay stable until that transfer, and
// IntAck sampled while IntReq=0 has no effect.
interface interrupt_controller_if #(
  parameter int NUM_IRQ = 4,
  parameter int ADDR_W  = 16
);
  logic [NUM_IRQ-1:0] IRQ;
  logic               IEWrite;
  logic [NUM_IRQ-1:0] IEData;
  logic               InstrBoundary;
  logic               IntAck;
  logic               RetI;
  logic [ADDR_W-1:0]  PC;
  logic               IntReq;
  logic [ADDR_W-1:0]  VectorAddr;
  logic [ADDR_W-1:0]  EPC;
  logic [2:0]         IntCause;
  logic [NUM_IRQ-1:0] Pending;
  logic               InService;
  logic [1:0]         fsm_state;

  // Controller side
  modport slave (
    input  IRQ, IEWrite, IEData, InstrBoundary, IntAck, RetI, PC,
    output IntReq, VectorAddr, EPC, IntCause, Pending, InService, fsm_state
  );

  // Control FSM / stimulus side
  modport master (
    output IRQ, IEWrite, IEData, InstrBoundary, IntAck, RetI, PC,
    input  IntReq, VectorAddr, EPC, IntCause, Pending, InService, fsm_state
  );
endinterface

// File: rtl/interrupt_controller.sv
// Priority interrupt controller: edge-detects IRQ lines into pending bits,
// selects the lowest enabled index at instruction boundaries, hands it to
// the control FSM, saves the return PC and blocks nesting until RetI.
module interrupt_controller #(
  parameter int                NUM_IRQ  = 4,
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] VEC_BASE = 'h0040
) (
  input logic                    CLK,
  input logic                    Reset_n,
  interrupt_controller_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_n;
  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] pending_n;
  logic [NUM_IRQ-1:0] mask;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] eligible;
  logic [2:0]         winner;
  logic [2:0]         int_cause;
  logic [ADDR_W-1:0]  epc;
  logic               take;   // IDLE -> REQ decision this cycle
  logic               ack;    // accepted handshake this cycle

  assign rise     = bus.IRQ & ~irq_q;
  assign eligible = pending & mask;
  assign take     = (state == IDLE) && bus.InstrBoundary && (|eligible);
  assign ack      = (state == REQ) && bus.IntAck;

  // Lowest-index enabled pending source wins
  always_comb begin
    winner = 3'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) winner = 3'(i);
    end
  end

  // FSM state register
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_n;
  end

  // FSM next-state: request only at a boundary, no nesting while in service
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (take) state_n = REQ;
      REQ:     if (bus.IntAck) state_n = SVC;
      SVC:     if (bus.RetI) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Pending update: ack clears the serviced bit, but a new edge wins
  always_comb begin
    pending_n = pending;
    if (ack) begin
      for (int i = 0; i < NUM_IRQ; i++) begin
        if (int_cause == 3'(i)) pending_n[i] = 1'b0;
      end
    end
    pending_n = pending_n | rise;
  end

  // Edge detector, pending bits and interrupt mask
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      irq_q   <= '0;
      pending <= '0;
      mask    <= '1;
    end else begin
      irq_q   <= bus.IRQ;
      pending <= pending_n;
      if (bus.IEWrite) mask <= bus.IEData;
    end
  end

  // Cause is frozen from the selection until the next selection; EPC on ack
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      int_cause <= 3'd0;
      epc       <= '0;
    end else begin
      if (take) int_cause <= winner;
      if (ack)  epc       <= bus.PC;
    end
  end

  assign bus.IntReq     = (state == REQ);
  assign bus.InService  = (state == SVC);
  assign bus.IntCause   = int_cause;
  assign bus.Pending    = pending;
  assign bus.EPC        = epc;
  // Vector n sits at VEC_BASE + 2n; overflow wraps within ADDR_W
  assign bus.VectorAddr = VEC_BASE + ADDR_W'({int_cause, 1'b0});
  assign bus.fsm_state  = state;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: hand-computed expectations
// checked with immediate assertions after each clock step.
module tb_interrupt_controller;

  localparam int NUM_IRQ = 4;
  localparam int ADDR_W  = 16;

  logic CLK;
  logic Reset_n;
  int   n_pass;
  int   n_total;

  interrupt_controller_if #(.NUM_IRQ(NUM_IRQ), .ADDR_W(ADDR_W)) bus ();

  interrupt_controller #(
    .NUM_IRQ (NUM_IRQ),
    .ADDR_W  (ADDR_W),
    .VEC_BASE(16'h0040)
  ) dut (
    .CLK    (CLK),
    .Reset_n(Reset_n),
    .bus    (bus)
  );

  // Clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one cycle; sample 1 ns after the rising edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_intreq"},  32'(bus.IntReq),     32'd0);
    chk({tag, "_pending"}, 32'(bus.Pending),    32'd0);
    chk({tag, "_epc"},     32'(bus.EPC),        32'd0);
    chk({tag, "_cause"},   32'(bus.IntCause),   32'd0);
    chk({tag, "_insvc"},   32'(bus.InService),  32'd0);
    chk({tag, "_vec"},     32'(bus.VectorAddr), 32'h0040);
    chk({tag, "_state"},   32'(bus.fsm_state),  32'd0);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    Reset_n = 1'b0;
    bus.IRQ = '0;
    bus.IEWrite = 1'b0;
    bus.IEData = '0;
    bus.InstrBoundary = 1'b0;
    bus.IntAck = 1'b0;
    bus.RetI = 1'b0;
    bus.PC = '0;

    // Reset values
    tick();
    tick();
    check_reset("rst");
    Reset_n = 1'b1;

    // Single source: IRQ[2]
    bus.InstrBoundary = 1'b1;
    bus.IRQ = 4'b0100;
    tick();
    chk("irq2_pending", 32'(bus.Pending), 32'b0100);
    chk("irq2_noreq_yet", 32'(bus.IntReq), 32'd0);
    bus.IRQ = 4'b0000;
    tick();
    chk("irq2_intreq", 32'(bus.IntReq), 32'd1);
    chk("irq2_cause", 32'(bus.IntCause), 32'd2);
    chk("irq2_vec", 32'(bus.VectorAddr), 32'h0044);

    // Ack with PC, then return
    bus.PC = 16'h1234;
    bus.IntAck = 1'b1;
    tick();
    chk("ack_epc", 32'(bus.EPC), 32'h1234);
    chk("ack_pending", 32'(bus.Pending), 32'd0);
    chk("ack_insvc", 32'(bus.InService), 32'd1);
    chk("ack_intreq", 32'(bus.IntReq), 32'd0);
    bus.IntAck = 1'b0;
    bus.RetI = 1'b1;
    tick();
    chk("reti_insvc", 32'(bus.InService), 32'd0);
    chk("reti_state", 32'(bus.fsm_state), 32'd0);
    bus.RetI = 1'b0;

    // IntAck outside REQ is ignored
    bus.PC = 16'h5555;
    bus.IntAck = 1'b1;
    tick();
    chk("stray_ack_epc", 32'(bus.EPC), 32'h1234);
    chk("stray_ack_state", 32'(bus.fsm_state), 32'd0);
    bus.IntAck = 1'b0;

    // IRQ[3] and IRQ[1] together: 1 first, then 3
    bus.IRQ = 4'b1010;
    tick();
    chk("dual_pending", 32'(bus.Pending), 32'b1010);
    bus.IRQ = 4'b0000;
    tick();
    chk("dual_intreq", 32'(bus.IntReq), 32'd1);
    chk("dual_cause1", 32'(bus.IntCause), 32'd1);
    chk("dual_vec1", 32'(bus.VectorAddr), 32'h0042);
    // Masking the requested line while in REQ does not change the request
    bus.IEWrite = 1'b1;
    bus.IEData = 4'b1101;
    tick();
    bus.IEWrite = 1'b0;
    chk("freeze_cause", 32'(bus.IntCause), 32'd1);
    chk("freeze_intreq", 32'(bus.IntReq), 32'd1);
    // RetI outside SVC is ignored
    bus.RetI = 1'b1;
    tick();
    chk("stray_reti_state", 32'(bus.fsm_state), 32'd1);
    bus.RetI = 1'b0;
    bus.IntAck = 1'b1;
    tick();
    chk("dual_ack_pending", 32'(bus.Pending), 32'b1000);
    chk("dual_ack_insvc", 32'(bus.InService), 32'd1);
    bus.IntAck = 1'b0;
    bus.RetI = 1'b1;
    tick();
    chk("dual_reti_state", 32'(bus.fsm_state), 32'd0);
    bus.RetI = 1'b0;
    tick();
    chk("dual_intreq3", 32'(bus.IntReq), 32'd1);
    chk("dual_cause3", 32'(bus.IntCause), 32'd3);
    chk("dual_vec3", 32'(bus.VectorAddr), 32'h0046);
    bus.IntAck = 1'b1;
    tick();
    bus.IntAck = 1'b0;
    bus.RetI = 1'b1;
    tick();
    bus.RetI = 1'b0;
    chk("dual_done_pending", 32'(bus.Pending), 32'd0);

    // Mask gates selection only
    bus.IEWrite = 1'b1;
    bus.IEData = 4'b1110;
    tick();
    bus.IEWrite = 1'b0;
    bus.IRQ = 4'b0001;
    tick();
    chk("mask_pending0", 32'(bus.Pending), 32'b0001);
    chk("mask_noreq_a", 32'(bus.IntReq), 32'd0);
    bus.IRQ = 4'b0000;
    tick();
    chk("mask_noreq_b", 32'(bus.IntReq), 32'd0);
    // Decision in the IEWrite cycle uses the old mask
    bus.IEWrite = 1'b1;
    bus.IEData = 4'b1111;
    tick();
    bus.IEWrite = 1'b0;
    chk("mask_oldmask_noreq", 32'(bus.IntReq), 32'd0);
    tick();
    chk("mask_intreq", 32'(bus.IntReq), 32'd1);
    chk("mask_cause0", 32'(bus.IntCause), 32'd0);
    chk("mask_vec0", 32'(bus.VectorAddr), 32'h0040);
    bus.IntAck = 1'b1;
    tick();
    bus.IntAck = 1'b0;
    bus.RetI = 1'b1;
    tick();
    bus.RetI = 1'b0;

    // Level held high: one pending set, one service
    bus.InstrBoundary = 1'b0;
    bus.IRQ = 4'b0010;
    repeat (10) tick();
    chk("level_pending", 32'(bus.Pending), 32'b0010);
    chk("level_noboundary_noreq", 32'(bus.IntReq), 32'd0);
    bus.IRQ = 4'b0000;
    bus.InstrBoundary = 1'b1;
    tick();
    chk("level_cause", 32'(bus.IntCause), 32'd1);
    bus.IntAck = 1'b1;
    tick();
    bus.IntAck = 1'b0;
    chk("level_ack_pending", 32'(bus.Pending), 32'd0);
    bus.RetI = 1'b1;
    tick();
    bus.RetI = 1'b0;
    tick();
    chk("level_single_service", 32'(bus.IntReq), 32'd0);

    // New edge coincident with IntAck: set wins
    bus.IRQ = 4'b0010;
    tick();
    bus.IRQ = 4'b0000;
    tick();
    chk("coinc_intreq", 32'(bus.IntReq), 32'd1);
    bus.IRQ = 4'b0010;
    bus.IntAck = 1'b1;
    tick();
    chk("coinc_pending", 32'(bus.Pending), 32'b0010);
    chk("coinc_insvc", 32'(bus.InService), 32'd1);
    bus.IRQ = 4'b0000;
    bus.IntAck = 1'b0;
    bus.RetI = 1'b1;
    tick();
    bus.RetI = 1'b0;
    tick();
    chk("coinc_reservice", 32'(bus.IntReq), 32'd1);
    chk("coinc_recause", 32'(bus.IntCause), 32'd1);

    // Asynchronous reset while in REQ
    #3;
    Reset_n = 1'b0;
    #1;
    check_reset("rst_req");
    @(posedge CLK);
    #1;
    Reset_n = 1'b1;

    // Asynchronous reset while in SVC with a non-zero EPC
    bus.IRQ = 4'b0100;
    tick();
    bus.IRQ = 4'b0000;
    tick();
    bus.PC = 16'hABCD;
    bus.IntAck = 1'b1;
    tick();
    bus.IntAck = 1'b0;
    chk("svc_epc", 32'(bus.EPC), 32'hABCD);
    chk("svc_insvc", 32'(bus.InService), 32'd1);
    #3;
    Reset_n = 1'b0;
    #1;
    check_reset("rst_svc");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
